// File: rtl/bias_relu_requant_stage.sv
// Per-lane bias add, ReLU and rounded requantisation behind the adder tree.
// Two register stages with valid/ready backpressure and a bias-group walker.
module bias_relu_requant_stage #(
    parameter int N_adder_tree = 16,
    parameter int NUM_GROUPS   = 3,
    parameter int ACC_W        = 18,
    parameter int SHIFT        = 8,
    parameter int OUT_W        = 8,
    localparam int GW          = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_GROUPS*N_adder_tree*ACC_W-1:0] bias_q,
    input  logic [N_adder_tree*ACC_W-1:0]          acc_in,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   group_clr,
    output logic [N_adder_tree*OUT_W-1:0]          out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic [GW-1:0]                          group_idx
);

    localparam int              QW      = ACC_W + OUT_W + 2;
    localparam logic [GW-1:0]   LAST_G  = GW'(NUM_GROUPS - 1);
    localparam logic [QW-1:0]   HALF    = (SHIFT > 0) ? (QW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [QW-1:0]   OUT_MAX = (QW'(1) << OUT_W) - QW'(1);

    logic                en;
    logic                accept;
    logic [GW-1:0]       grp_used;
    logic                grp_is_last;
    logic                s1_valid;
    logic                s1_last;
    logic [ACC_W-1:0]    s1_r  [N_adder_tree];
    logic [ACC_W-1:0]    r_nxt [N_adder_tree];
    logic [OUT_W-1:0]    q_nxt [N_adder_tree];

    // The widened sum cannot overflow; a set sign bit means ReLU clamps to zero.
    function automatic logic [ACC_W-1:0] bias_relu(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        return sum[ACC_W] ? '0 : sum[ACC_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] r);
        logic [QW-1:0] q;
        q = (QW'(r) + HALF) >> SHIFT;
        return (q > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : q[OUT_W-1:0];
    endfunction

    assign en          = ~out_valid | out_ready;
    assign in_ready    = en;
    assign accept      = in_valid & en;
    assign grp_used    = group_clr ? '0 : group_idx;
    assign grp_is_last = (grp_used == LAST_G);

    always_comb begin
        for (int i = 0; i < N_adder_tree; i++) begin
            r_nxt[i] = bias_relu(acc_in[ACC_W*i +: ACC_W],
                                 bias_q[ACC_W*(int'(grp_used)*N_adder_tree + i) +: ACC_W]);
            q_nxt[i] = requant(s1_r[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            for (int i = 0; i < N_adder_tree; i++) s1_r[i] <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= grp_is_last;
                for (int i = 0; i < N_adder_tree; i++) s1_r[i] <= r_nxt[i];
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_last <= s1_last;
                for (int i = 0; i < N_adder_tree; i++) out_data[OUT_W*i +: OUT_W] <= q_nxt[i];
            end
        end
    end

    // group_clr restarts the walk even when no beat is accepted that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            group_idx <= '0;
        end else if (accept) begin
            group_idx <= grp_is_last ? '0 : grp_used + GW'(1);
        end else if (group_clr) begin
            group_idx <= '0;
        end
    end

endmodule
